ddr3_wb_cache: RTL and testbench
================================

# ddr3_wb_cache

Parametrised write-back, direct-mapped line cache between the 32-bit system bus and the wide-line DDR3 controller port. It adds byte-enable writes, an explicit flush command that writes back all dirty lines, and hit/miss counters. Line width, line count and address width are generics, so one block serves any DDR3 controller line size.

## Interface
- `ADDR_BITS`, 29: byte-address width of the backing memory.
- `LINE_BITS`, 256: cache line and controller data width. Power of two, ≥ 64.
- `LINES`, 512: number of cache lines. Power of two, ≥ 2.
- Derived: OFF_BITS = log2(LINE_BITS/8); IDX_BITS = log2(LINES); TAG_BITS = ADDR_BITS − OFF_BITS − IDX_BITS.
- Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr_i` in ADDR_BITS: byte address. Bits [1:0] are ignored.
- `data_i` in 32: write word.
- `be_i` in 4: byte enables for writes.
- `rd_i` / `we_i` / `flush_i` in 1 each: request strobes. Each is held until `ack_o`.
- `data_o` out 32: read word. Valid only while `ack_o` is high.
- `ack_o` out 1: one-cycle completion pulse.
- `mem_addr_o` out ADDR_BITS: line-aligned address. Offset bits are 0.
- `mem_data_o` out LINE_BITS: write-back line.
- `mem_data_i` in LINE_BITS: fill line.
- `mem_rd_o` / `mem_we_o` out 1: controller requests.
- `mem_ack_i` in 1: controller completion.
- `hit_cnt_o` / `miss_cnt_o` out 32: lookup statistics.

## Operation
- Address split: tag = addr[ADDR_BITS−1 : OFF_BITS+IDX_BITS]; idx = addr[OFF_BITS+IDX_BITS−1 : OFF_BITS]; word = addr[OFF_BITS−1 : 2].
- Per-line state in flops: tag, valid, dirty. Line data lives in the sync-read RAM.
- IDLE priority: rd_i, then we_i, then flush_i. On acceptance, latch address, data and byte enables, and issue the RAM read.
- States and transitions:
  - IDLE → LOOKUP (rd or we), or IDLE → FLUSH_SCAN (flush).
  - LOOKUP: hit = valid && tag match. Hit counter increments on a hit; miss counter increments on a miss. Each wraps at 2^32.
    - Read hit → ACK.
    - Write hit → MERGE.
    - Miss with dirty line → EVICT.
    - Miss with clean line → FILL.
  - EVICT: `mem_we_o`=1 with addr = {old tag, idx, 0} and data = RAM line. On `mem_ack_i`: clear dirty, go to FILL.
  - FILL: `mem_rd_o`=1 with addr = {new tag, idx, 0}. On `mem_ack_i`: write the line to RAM and a line register, set valid, update tag. Then read → ACK, write → MERGE.
  - MERGE: replace the selected word byte-wise per `be_i`, write the line to RAM, set dirty → ACK. When `be_i`=0, data is unchanged but dirty is still set.
  - ACK: `ack_o`=1 → IDLE. For reads, `data_o` = selected word of the line (from RAM on a hit, from the fill register on a miss).
  - FLUSH_SCAN: check idx counter k.
    - If valid && dirty: issue RAM read → FLUSH_RD (1 cycle) → FLUSH_WB. FLUSH_WB holds `mem_we_o` until `mem_ack_i`, then clears dirty[k].
    - Then k == LINES−1 → ACK; otherwise k+1 → FLUSH_SCAN.
    - Valid bits are kept. Flush does not touch the counters.
- Requester rules:
  - Drops the strobe on the edge where it samples `ack_o`.
  - Never asserts rd_i and we_i together. If it does, the request is treated as a read.
  - Strobes changing mid-transaction are ignored; the latched copy governs.

## Timing
- Reset values: ack_o, data_o, mem_rd_o, mem_we_o, mem_addr_o, mem_data_o, hit_cnt_o, miss_cnt_o = 0. All valid and dirty bits = 0. RAM contents are not cleared.
- Reset mid-transaction: abandon immediately. Memory strobes are 0 the cycle after reset is sampled, and pending dirty data is lost.
- Accept at cycle 0, with ACK cycle:
  - Read hit: ACK at cycle 2.
  - Write hit: ACK at cycle 3.
  - Clean miss: ACK at 2 + F + 1 (+1 more for a write), where F = cycles until `mem_ack_i`.
  - Dirty miss: adds E + 1, where E = eviction wait.
- Flush on a fully clean cache: ACK exactly LINES + 1 cycles after acceptance.
- Memory handshake:
  - Strobe, address and data stay stable until `mem_ack_i` is sampled high.
  - Strobe drops the next cycle.
  - `mem_ack_i` outside a request is ignored.
- RAM read-during-write returns old data. The design never relies on it.

## Structure
- Shared header `ddr3_defs.vh`: state encodings, address-split helper macros. Reuses the `GET_WIDTH` macro from `functions.vh` for OFF_BITS and IDX_BITS.
- Sub-module `ddr3_line_ram`: single-port, LINES × LINE_BITS, 1-cycle synchronous read, write enable.

## Test plan
- Reset, then read 0x0000_0040 (memory returns line pattern 0x…0807060504030201):
  - Expect one `mem_rd_o` at 0x40 and `data_o` = word 0 of that line.
  - `miss_cnt_o`=1.
  - Repeat the read: ACK at cycle 2, no memory traffic, `hit_cnt_o`=1.
- Write 0xDEADBEEF, `be_i`=4'b0101 to 0x44 (resident line, old word 0x11223344):
  - Read-back of 0x44 = 0x11AD33EF.
  - No memory write.
- Dirty conflict (LINES=512, LINE_BITS=256): write 0x100, then read 0x100+0x4000.
  - Expect a `mem_we_o` at 0x100 carrying the merged line, then `mem_rd_o` at 0x4100.
- Flush with dirty lines at idx 3 and 510:
  - Exactly two memory writes, in index order.
  - Second flush: ACK after LINES+1 cycles with no writes.
- `mem_ack_i` delayed 20 cycles, with `rst` pulsed at cycle 10 of a fill:
  - Strobes are 0 the next cycle.
  - All counters are 0.
  - A subsequent read misses.
- Preload `miss_cnt_o` to 0xFFFF_FFFF, then one miss: counter wraps to 0.

Source files
------------

// File: rtl/ddr3_wb_cache_pkg.sv
// Shared types for the write-back DDR3 line cache: controller states and the
// byte-enable word merge.
package ddr3_wb_cache_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_MERGE,
        S_ACK,
        S_FLUSH_SCAN,
        S_FLUSH_RD,
        S_FLUSH_WB
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr3_wb_cache_line_ram.sv
// Single-port line store: LINES x LINE_BITS, one-cycle registered read,
// read-during-write returns the old contents.
module ddr3_line_ram #(
    parameter int LINES     = 512,
    parameter int LINE_BITS = 256
) (
    input  logic                       clk,
    input  logic                       re,
    input  logic                       we,
    input  logic [$clog2(LINES)-1:0]   addr,
    input  logic [LINE_BITS-1:0]       wdata,
    output logic [LINE_BITS-1:0]       rdata
);

    logic [LINE_BITS-1:0] mem [LINES];

    // NOTE: the array and read register have no reset so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/ddr3_wb_cache.sv
// Direct-mapped write-back cache between a 32-bit bus and a wide-line DDR3
// controller port, with byte-enable writes, full flush and hit/miss counters.
module ddr3_wb_cache
    import ddr3_wb_cache_pkg::*;
#(
    parameter int ADDR_BITS = 29,
    parameter int LINE_BITS = 256,
    parameter int LINES     = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [31:0]           data_i,
    input  logic [3:0]            be_i,
    input  logic                  rd_i,
    input  logic                  we_i,
    input  logic                  flush_i,
    output logic [31:0]           data_o,
    output logic                  ack_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [LINE_BITS-1:0]  mem_data_o,
    input  logic [LINE_BITS-1:0]  mem_data_i,
    output logic                  mem_rd_o,
    output logic                  mem_we_o,
    input  logic                  mem_ack_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int TAG_BITS  = ADDR_BITS - OFF_BITS - IDX_BITS;
    localparam int WORD_BITS = OFF_BITS - 2;
    localparam int SEL_BITS  = $clog2(LINE_BITS);

    state_t                 state, state_next;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            data_q;
    logic [3:0]             be_q;
    logic                   is_read;
    logic [IDX_BITS-1:0]    scan_idx;
    logic [LINE_BITS-1:0]   line_buf, merged;
    logic [TAG_BITS-1:0]    tags [LINES];
    logic [LINES-1:0]       valid, dirty;
    logic [31:0]            hit_cnt, miss_cnt;

    logic                   ram_re, ram_we;
    logic [IDX_BITS-1:0]    ram_addr;
    logic [LINE_BITS-1:0]   ram_wdata, ram_rdata;

    logic [TAG_BITS-1:0]    tag;
    logic [IDX_BITS-1:0]    idx;
    logic [SEL_BITS-1:0]    word_sel;
    logic                   hit, scan_last;
    logic                   unused_addr_bits;

    assign tag              = addr_q[ADDR_BITS-1 -: TAG_BITS];
    assign idx              = addr_q[OFF_BITS +: IDX_BITS];
    assign word_sel         = {addr_q[2 +: WORD_BITS], 5'b00000};
    assign hit              = valid[idx] && (tags[idx] == tag);
    assign scan_last        = (scan_idx == IDX_BITS'(LINES - 1));
    assign unused_addr_bits = ^addr_q[1:0];
    assign hit_cnt_o        = hit_cnt;
    assign miss_cnt_o       = miss_cnt;

    ddr3_line_ram #(.LINES(LINES), .LINE_BITS(LINE_BITS)) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        merged = line_buf;
        merged[word_sel +: 32] = merge_bytes(line_buf[word_sel +: 32], data_q, be_q);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ack_o      = 1'b0;
        data_o     = '0;
        mem_rd_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = idx;
        ram_wdata  = merged;
        case (state)
            S_IDLE: begin
                if (rd_i || we_i) begin
                    state_next = S_LOOKUP;
                    ram_re     = 1'b1;
                    ram_addr   = addr_i[OFF_BITS +: IDX_BITS];
                end else if (flush_i) begin
                    state_next = S_FLUSH_SCAN;
                end
            end
            S_LOOKUP: begin
                if (hit)             state_next = is_read ? S_ACK : S_MERGE;
                else if (dirty[idx]) state_next = S_EVICT;
                else                 state_next = S_FILL;
            end
            S_EVICT: begin
                mem_we_o   = 1'b1;
                mem_addr_o = {tags[idx], idx, {OFF_BITS{1'b0}}};
                mem_data_o = line_buf;
                if (mem_ack_i) state_next = S_FILL;
            end
            S_FILL: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = {tag, idx, {OFF_BITS{1'b0}}};
                if (mem_ack_i) begin
                    ram_we     = 1'b1;
                    ram_wdata  = mem_data_i;
                    state_next = is_read ? S_ACK : S_MERGE;
                end
            end
            S_MERGE: begin
                ram_we     = 1'b1;
                state_next = S_ACK;
            end
            S_ACK: begin
                ack_o      = 1'b1;
                if (is_read) data_o = line_buf[word_sel +: 32];
                state_next = S_IDLE;
            end
            S_FLUSH_SCAN: begin
                if (valid[scan_idx] && dirty[scan_idx]) begin
                    ram_re     = 1'b1;
                    ram_addr   = scan_idx;
                    state_next = S_FLUSH_RD;
                end else if (scan_last) begin
                    state_next = S_ACK;
                end
            end
            S_FLUSH_RD: state_next = S_FLUSH_WB;
            S_FLUSH_WB: begin
                mem_we_o   = 1'b1;
                mem_addr_o = {tags[scan_idx], scan_idx, {OFF_BITS{1'b0}}};
                mem_data_o = line_buf;
                if (mem_ack_i) state_next = scan_last ? S_ACK : S_FLUSH_SCAN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            valid    <= '0;
            dirty    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (rd_i || we_i || flush_i) begin
                        addr_q   <= addr_i;
                        data_q   <= data_i;
                        be_q     <= be_i;
                        is_read  <= rd_i;
                        scan_idx <= '0;
                    end
                end
                S_LOOKUP: begin
                    line_buf <= ram_rdata;
                    if (hit) hit_cnt  <= hit_cnt + 32'd1;
                    else     miss_cnt <= miss_cnt + 32'd1;
                end
                S_EVICT: if (mem_ack_i) dirty[idx] <= 1'b0;
                S_FILL: begin
                    if (mem_ack_i) begin
                        line_buf   <= mem_data_i;
                        valid[idx] <= 1'b1;
                        tags[idx]  <= tag;
                    end
                end
                S_MERGE: begin
                    line_buf   <= merged;
                    dirty[idx] <= 1'b1;
                end
                S_FLUSH_SCAN: begin
                    if (!(valid[scan_idx] && dirty[scan_idx])) scan_idx <= scan_idx + IDX_BITS'(1);
                end
                S_FLUSH_RD: line_buf <= ram_rdata;
                S_FLUSH_WB: begin
                    if (mem_ack_i) begin
                        dirty[scan_idx] <= 1'b0;
                        scan_idx        <= scan_idx + IDX_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_wb_cache.sv
// Directed bench for ddr3_wb_cache: a vector table for hits, misses, merges and
// evictions, plus sequences for flush, reset during a fill and counter wrap.
module tb_ddr3_wb_cache;

    localparam int ADDR_BITS = 29;
    localparam int LINE_BITS = 256;
    localparam int LINES     = 512;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_BITS-1:0]  addr_i;
    logic [31:0]           data_i;
    logic [3:0]            be_i;
    logic                  rd_i, we_i, flush_i;
    logic [31:0]           data_o;
    logic                  ack_o;
    logic [ADDR_BITS-1:0]  mem_addr_o;
    logic [LINE_BITS-1:0]  mem_data_o;
    logic [LINE_BITS-1:0]  mem_data_i;
    logic                  mem_rd_o, mem_we_o;
    logic                  mem_ack_i;
    logic [31:0]           hit_cnt_o, miss_cnt_o;

    always #5 clk = ~clk;

    ddr3_wb_cache #(.ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .LINES(LINES)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .be_i       (be_i),
        .rd_i       (rd_i),
        .we_i       (we_i),
        .flush_i    (flush_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_rd_o   (mem_rd_o),
        .mem_we_o   (mem_we_o),
        .mem_ack_i  (mem_ack_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        else
            n_pass++;
    endtask

    // Fill data: byte i of the line at address a is (i+1) + a[15:8].
    function automatic logic [255:0] pat(input logic [ADDR_BITS-1:0] a);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'(i + 1) + a[15:8];
        return r;
    endfunction

    // Controller model: acks after mem_lat wait cycles, logs every completed transfer.
    int                    mem_lat = 2;
    int                    wait_cnt = 0;
    int                    n_rd = 0, n_wr = 0, log_n = 0;
    logic                  log_we   [64];
    logic [ADDR_BITS-1:0]  log_addr [64];
    logic [255:0]          log_data [64];

    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (mem_rd_o || mem_we_o) begin
            wait_cnt++;
            if (wait_cnt > mem_lat) begin
                wait_cnt   = 0;
                mem_ack_i  = 1'b1;
                mem_data_i = pat(mem_addr_o);
                if (log_n < 64) begin
                    log_we[log_n]   = mem_we_o;
                    log_addr[log_n] = mem_addr_o;
                    log_data[log_n] = mem_data_o;
                end
                log_n++;
                if (mem_we_o) n_wr++;
                else          n_rd++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Issues one request and returns the ack cycle counted from acceptance (cycle 0).
    task automatic do_op(input logic rd, input logic we, input logic fl,
                         input logic [ADDR_BITS-1:0] a, input logic [31:0] d, input logic [3:0] b,
                         output logic [31:0] rdata, output int lat);
        bit done = 0;
        rdata = '0;
        lat   = -1;
        @(negedge clk);
        rd_i = rd; we_i = we; flush_i = fl; addr_i = a; data_i = d; be_i = b;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_o) begin
                lat   = k + 1;
                rdata = data_o;
                done  = 1;
            end
        end
        rd_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
        check("ack_seen", 256'(done), 256'(1));
    endtask

    typedef struct {
        logic                 rd;
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [31:0]          data;
        logic [3:0]           be;
        logic [31:0]          exp_data;
        int                   exp_hit;
        int                   exp_miss;
        int                   exp_rds;
        int                   exp_wrs;
        int                   exp_lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0]  rdata;
        logic [255:0] exp_line;
        int           lat, rd0, wr0, n0, seen;

        vecs[0]  = '{1'b1, 1'b0, 29'h40,   32'h0,        4'h0, 32'h04030201, 0, 1, 1, 0, 5};
        vecs[1]  = '{1'b1, 1'b0, 29'h40,   32'h0,        4'h0, 32'h04030201, 1, 1, 0, 0, 2};
        vecs[2]  = '{1'b1, 1'b0, 29'h44,   32'h0,        4'h0, 32'h08070605, 2, 1, 0, 0, 2};
        vecs[3]  = '{1'b0, 1'b1, 29'h44,   32'h11223344, 4'hF, 32'h0,        3, 1, 0, 0, 3};
        vecs[4]  = '{1'b0, 1'b1, 29'h44,   32'hDEADBEEF, 4'h5, 32'h0,        4, 1, 0, 0, 3};
        vecs[5]  = '{1'b1, 1'b0, 29'h44,   32'h0,        4'h0, 32'h11AD33EF, 5, 1, 0, 0, 2};
        vecs[6]  = '{1'b0, 1'b1, 29'h48,   32'h55555555, 4'h0, 32'h0,        6, 1, 0, 0, 3};
        vecs[7]  = '{1'b1, 1'b0, 29'h48,   32'h0,        4'h0, 32'h0C0B0A09, 7, 1, 0, 0, 2};
        vecs[8]  = '{1'b0, 1'b1, 29'h100,  32'hCAFEF00D, 4'hF, 32'h0,        7, 2, 1, 0, 6};
        vecs[9]  = '{1'b1, 1'b0, 29'h4100, 32'h0,        4'h0, 32'h45444342, 7, 3, 1, 1, 8};
        vecs[10] = '{1'b1, 1'b0, 29'h104,  32'h0,        4'h0, 32'h09080706, 7, 4, 1, 0, 5};
        vecs[11] = '{1'b1, 1'b1, 29'h104,  32'h0,        4'h0, 32'h09080706, 8, 4, 0, 0, 2};

        rst = 1'b1; rd_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
        addr_i = '0; data_i = '0; be_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",      256'(ack_o),      256'(0));
        check("rst_data",     256'(data_o),     256'(0));
        check("rst_mem_rd",   256'(mem_rd_o),   256'(0));
        check("rst_mem_we",   256'(mem_we_o),   256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o,       256'(0));
        check("rst_hits",     256'(hit_cnt_o),  256'(0));
        check("rst_misses",   256'(miss_cnt_o), 256'(0));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rd0 = n_rd;
            wr0 = n_wr;
            do_op(vecs[i].rd, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].data, vecs[i].be, rdata, lat);
            if (vecs[i].rd) check($sformatf("v%0d_data", i), 256'(rdata), 256'(vecs[i].exp_data));
            check($sformatf("v%0d_hits", i),   256'(hit_cnt_o),  256'(vecs[i].exp_hit));
            check($sformatf("v%0d_misses", i), 256'(miss_cnt_o), 256'(vecs[i].exp_miss));
            check($sformatf("v%0d_mem_rds", i), 256'(n_rd - rd0), 256'(vecs[i].exp_rds));
            check($sformatf("v%0d_mem_wrs", i), 256'(n_wr - wr0), 256'(vecs[i].exp_wrs));
            check($sformatf("v%0d_latency", i), 256'(lat), 256'(vecs[i].exp_lat));
        end

        // Dirty conflict: the eviction of 0x100 carries the merged line, then 0x4100 is filled.
        exp_line = pat(29'h100);
        exp_line[31:0] = 32'hCAFEF00D;
        check("evict_is_write", 256'(log_we[2]),   256'(1));
        check("evict_addr",     256'(log_addr[2]), 256'(29'h100));
        check("evict_data",     log_data[2],       exp_line);
        check("refill_is_read", 256'(log_we[3]),   256'(0));
        check("refill_addr",    256'(log_addr[3]), 256'(29'h4100));

        // Reset pulsed ten cycles into a slow fill.
        mem_lat = 20;
        n0 = log_n;
        seen = 0;
        @(negedge clk);
        rd_i = 1'b1; addr_i = 29'h8000;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (mem_rd_o) seen = 1;
        end
        check("slow_fill_started", 256'(seen), 256'(1));
        repeat (10) @(negedge clk);
        rd_i = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_fill_mem_rd", 256'(mem_rd_o),    256'(0));
        check("rst_fill_mem_we", 256'(mem_we_o),    256'(0));
        check("rst_fill_ack",    256'(ack_o),       256'(0));
        check("rst_fill_hits",   256'(hit_cnt_o),   256'(0));
        check("rst_fill_misses", 256'(miss_cnt_o),  256'(0));
        check("rst_fill_no_xfer", 256'(log_n - n0), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 2;
        do_op(1'b1, 1'b0, 1'b0, 29'h40, 32'h0, 4'h0, rdata, lat);
        check("post_rst_data",    256'(rdata),      256'(32'h04030201));
        check("post_rst_latency", 256'(lat),        256'(5));
        check("post_rst_misses",  256'(miss_cnt_o), 256'(1));

        // Flush with dirty lines at indices 3 and 510.
        do_op(1'b0, 1'b1, 1'b0, 29'h60,   32'h12345678, 4'hF, rdata, lat);
        do_op(1'b0, 1'b1, 1'b0, 29'h3FC0, 32'h9ABCDEF0, 4'hF, rdata, lat);
        n0  = log_n;
        wr0 = n_wr;
        do_op(1'b0, 1'b0, 1'b1, 29'h0, 32'h0, 4'h0, rdata, lat);
        check("flush_wr_count", 256'(n_wr - wr0), 256'(2));
        exp_line = pat(29'h60);
        exp_line[31:0] = 32'h12345678;
        check("flush_wb0_we",   256'(log_we[n0]),   256'(1));
        check("flush_wb0_addr", 256'(log_addr[n0]), 256'(29'h60));
        check("flush_wb0_data", log_data[n0],       exp_line);
        exp_line = pat(29'h3FC0);
        exp_line[31:0] = 32'h9ABCDEF0;
        check("flush_wb1_addr", 256'(log_addr[n0+1]), 256'(29'h3FC0));
        check("flush_wb1_data", log_data[n0+1],       exp_line);
        check("flush_hits",     256'(hit_cnt_o),  256'(0));
        check("flush_misses",   256'(miss_cnt_o), 256'(3));

        wr0 = n_wr;
        do_op(1'b0, 1'b0, 1'b1, 29'h0, 32'h0, 4'h0, rdata, lat);
        check("clean_flush_latency", 256'(lat),        256'(LINES + 1));
        check("clean_flush_wrs",     256'(n_wr - wr0), 256'(0));

        do_op(1'b1, 1'b0, 1'b0, 29'h60, 32'h0, 4'h0, rdata, lat);
        check("after_flush_data",    256'(rdata),     256'(32'h12345678));
        check("after_flush_latency", 256'(lat),       256'(2));
        check("after_flush_hits",    256'(hit_cnt_o), 256'(1));

        // Miss counter wrap from all-ones.
        @(negedge clk);
        force dut.miss_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.miss_cnt;
        check("preload_misses", 256'(miss_cnt_o), 256'(32'hFFFF_FFFF));
        do_op(1'b1, 1'b0, 1'b0, 29'hC000, 32'h0, 4'h0, rdata, lat);
        check("wrap_misses", 256'(miss_cnt_o), 256'(0));
        check("wrap_data",   256'(rdata),      256'(32'h04030201 + 32'hC0C0C0C0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
